// File: rtl/dcache_responder.sv
// dcache_responder
// Direct-mapped, write-through, no-write-allocate data cache with one
// 64-bit word per line. Loads that hit return data in the same cycle.
// Load misses and all stores raise mem_block_flag_o and go out on a
// single-outstanding req/ack bus. dcache_ready_o pulses for one cycle
// when the blocked access completes.
module dcache_responder #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned INDEX_W    = 6,
    parameter logic [1:0]  CTRL_BLOCK = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ctrl_signal_dcache_i,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [7:0]        mem_wmask_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_block_flag_o,
    output logic              dcache_ready_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [7:0]        bus_wmask_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    localparam int unsigned LINES = 1 << INDEX_W;
    localparam int unsigned TAG_W = ADDR_W - INDEX_W - 3;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Line storage: tags and data are not reset, only the valid bits are.
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic [LINES-1:0]  valid;

    // Access captured at accept time, held stable for the bus transaction.
    logic [ADDR_W-4:0] line_addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;
    logic [DATA_W-1:0] rdata_q;

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] lat_idx;
    logic [TAG_W-1:0]   lat_tag;
    logic               req_hit;
    logic               lat_hit;
    logic               accept;
    logic               bus_done;
    logic               unused_addr_lsbs;

    // Byte offset within the word plays no part in lookup.
    assign unused_addr_lsbs = ^mem_addr_i[2:0];

    assign req_idx = mem_addr_i[INDEX_W+2:3];
    assign req_tag = mem_addr_i[ADDR_W-1:INDEX_W+3];
    assign lat_idx = line_addr_q[INDEX_W-1:0];
    assign lat_tag = line_addr_q[ADDR_W-4:INDEX_W];

    assign req_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign lat_hit = valid[lat_idx] && (tag_mem[lat_idx] == lat_tag);

    // New accesses are only taken in IDLE, out of reset, and when CTRL is not freezing.
    assign accept   = rst && (state == IDLE) && mem_req_i
                      && (ctrl_signal_dcache_i != CTRL_BLOCK);
    // Ack counts only while a request is actually outstanding.
    assign bus_done = bus_ack_i && ((state == RD_MISS) || (state == WR_THRU));

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next       = state;
        mem_rdata_o      = '0;
        mem_block_flag_o = 1'b0;
        dcache_ready_o   = 1'b0;
        bus_req_o        = 1'b0;
        bus_we_o         = 1'b0;
        bus_addr_o       = '0;
        bus_wdata_o      = '0;
        bus_wmask_o      = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (mem_we_i) begin
                        mem_block_flag_o = 1'b1;
                        state_next       = WR_THRU;
                    end else if (req_hit) begin
                        mem_rdata_o = data_mem[req_idx];
                    end else begin
                        mem_block_flag_o = 1'b1;
                        state_next       = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                bus_req_o  = 1'b1;
                bus_addr_o = {line_addr_q, 3'b000};
                if (bus_ack_i) begin
                    state_next = DONE;
                end
            end
            WR_THRU: begin
                bus_req_o   = 1'b1;
                bus_we_o    = 1'b1;
                bus_addr_o  = {line_addr_q, 3'b000};
                bus_wdata_o = wdata_q;
                bus_wmask_o = wmask_q;
                if (bus_ack_i) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                dcache_ready_o = 1'b1;
                mem_rdata_o    = rdata_q;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the accepted access; rdata_q starts at 0 so stores report 0 in DONE.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_addr_q <= mem_addr_i[ADDR_W-1:3];
            wdata_q     <= mem_wdata_i;
            wmask_q     <= mem_wmask_i;
            rdata_q     <= '0;
        end else if (rst && bus_done && (state == RD_MISS)) begin
            rdata_q <= bus_rdata_i;
        end
    end

    // Valid bits: cleared by reset, set on a read fill.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
        end else if (bus_done && (state == RD_MISS)) begin
            valid[lat_idx] <= 1'b1;
        end
    end

    // Tag/data update: fill on read miss, byte-merge on write-through hit only.
    always_ff @(posedge clk) begin
        if (rst && bus_done) begin
            if (state == RD_MISS) begin
                tag_mem[lat_idx]  <= lat_tag;
                data_mem[lat_idx] <= bus_rdata_i;
            end else if (lat_hit) begin
                for (int unsigned b = 0; b < 8; b++) begin
                    if (wmask_q[b]) begin
                        data_mem[lat_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: a table of directed accesses
// with hand-computed results, plus reset, freeze and reset-mid-miss sequences.
module tb_dcache_responder;

    localparam logic [1:0] BLK = 2'b01;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ctrl;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;
    logic        mem_block_flag;
    logic        dcache_ready;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_ack;
    logic [63:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          delay;
        logic [63:0] brdata;
        logic        exp_hit;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[13];

    dcache_responder #(
        .ADDR_W(64),
        .DATA_W(64),
        .INDEX_W(6),
        .CTRL_BLOCK(BLK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctrl_signal_dcache_i(ctrl),
        .mem_req_i(mem_req),
        .mem_we_i(mem_we),
        .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata),
        .mem_wmask_i(mem_wmask),
        .mem_rdata_o(mem_rdata),
        .mem_block_flag_o(mem_block_flag),
        .dcache_ready_o(dcache_ready),
        .bus_req_o(bus_req),
        .bus_we_o(bus_we),
        .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata),
        .bus_wmask_o(bus_wmask),
        .bus_ack_i(bus_ack),
        .bus_rdata_i(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access: present it, check the IDLE-cycle response, then serve the bus.
    task automatic run_vec(input vec_t v);
        @(posedge clk);
        #1;
        mem_req   = 1'b1;
        mem_we    = v.we;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wmask = v.wmask;
        ctrl      = 2'b00;
        #3;
        check("block_flag", {63'd0, mem_block_flag}, {63'd0, !v.exp_hit});
        if (v.exp_hit) check("hit_rdata", mem_rdata, v.exp_rdata);
        @(posedge clk);
        #1;
        mem_req = 1'b0;
        if (v.exp_hit) begin
            check("hit_no_bus_req", {63'd0, bus_req}, 64'd0);
            return;
        end
        ctrl = BLK;
        for (int c = 0; c <= v.delay; c++) begin
            check("bus_req", {63'd0, bus_req}, 64'd1);
            check("bus_we", {63'd0, bus_we}, {63'd0, v.we});
            check("bus_addr", bus_addr, v.addr & ~64'h7);
            check("flag_low_in_txn", {63'd0, mem_block_flag}, 64'd0);
            if (v.we) begin
                check("bus_wdata", bus_wdata, v.wdata);
                check("bus_wmask", {56'd0, bus_wmask}, {56'd0, v.wmask});
            end
            if (c == v.delay) begin
                bus_ack   = 1'b1;
                bus_rdata = v.brdata;
            end
            @(posedge clk);
            #1;
            bus_ack   = 1'b0;
            bus_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        end
        check("ready_pulse", {63'd0, dcache_ready}, 64'd1);
        check("done_rdata", mem_rdata, v.exp_rdata);
        check("done_bus_req", {63'd0, bus_req}, 64'd0);
        ctrl = 2'b00;
        @(posedge clk);
        #1;
        check("ready_drop", {63'd0, dcache_ready}, 64'd0);
    endtask

    initial begin
        //           we    addr                wdata                wmask  dly brdata               hit   exp_rdata
        vecs[0]  = '{1'b0, 64'h8000_0000, 64'h0,                8'h00, 4, 64'h1122334455667788, 1'b0, 64'h1122334455667788};
        vecs[1]  = '{1'b0, 64'h8000_0004, 64'h0,                8'h00, 0, 64'h0,                1'b1, 64'h1122334455667788};
        vecs[2]  = '{1'b1, 64'h8000_0000, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1, 64'h0,                1'b0, 64'h0};
        vecs[3]  = '{1'b0, 64'h8000_0000, 64'h0,                8'h00, 0, 64'h0,                1'b1, 64'h11223344FFFFFFFF};
        vecs[4]  = '{1'b1, 64'h8000_1000, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 0, 64'h0,                1'b0, 64'h0};
        vecs[5]  = '{1'b0, 64'h8000_1000, 64'h0,                8'h00, 0, 64'hDEADBEEFCAFEF00D, 1'b0, 64'hDEADBEEFCAFEF00D};
        vecs[6]  = '{1'b0, 64'h8000_1008, 64'h0,                8'h00, 2, 64'h0102030405060708, 1'b0, 64'h0102030405060708};
        vecs[7]  = '{1'b0, 64'h8000_1000, 64'h0,                8'h00, 0, 64'h0,                1'b1, 64'hDEADBEEFCAFEF00D};
        vecs[8]  = '{1'b0, 64'h8000_0200, 64'h0,                8'h00, 1, 64'h5555AAAA5555AAAA, 1'b0, 64'h5555AAAA5555AAAA};
        vecs[9]  = '{1'b0, 64'h8000_0000, 64'h0,                8'h00, 0, 64'h0F0F0F0F0F0F0F0F, 1'b0, 64'h0F0F0F0F0F0F0F0F};
        vecs[10] = '{1'b1, 64'h8000_0000, 64'h1111111111111111, 8'h81, 3, 64'h0,                1'b0, 64'h0};
        vecs[11] = '{1'b0, 64'h8000_0000, 64'h0,                8'h00, 0, 64'h0,                1'b1, 64'h110F0F0F0F0F0F11};
        vecs[12] = '{1'b0, 64'h8000_1008, 64'h0,                8'h00, 0, 64'h0,                1'b1, 64'h0102030405060708};

        rst       = 1'b0;
        ctrl      = 2'b00;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = 64'h8000_0000;
        mem_wdata = '0;
        mem_wmask = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;

        // Reset held two cycles with a request pending: everything stays quiet.
        repeat (2) @(posedge clk);
        #1;
        check("rst_block_flag", {63'd0, mem_block_flag}, 64'd0);
        check("rst_bus_req", {63'd0, bus_req}, 64'd0);
        check("rst_ready", {63'd0, dcache_ready}, 64'd0);
        check("rst_rdata", mem_rdata, 64'd0);
        check("rst_bus_addr", bus_addr, 64'd0);
        rst     = 1'b1;
        mem_req = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Freeze in IDLE: request ignored, no flag, no bus activity.
        @(posedge clk);
        #1;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 64'h8000_4000;
        ctrl     = BLK;
        #3;
        check("freeze_flag", {63'd0, mem_block_flag}, 64'd0);
        check("freeze_rdata", mem_rdata, 64'd0);
        @(posedge clk);
        #1;
        check("freeze_bus_req", {63'd0, bus_req}, 64'd0);
        mem_addr = 64'h8000_0000;
        #3;
        check("freeze_hit_rdata", mem_rdata, 64'd0);
        @(posedge clk);
        #1;
        mem_req = 1'b0;
        ctrl    = 2'b00;
        // Stray ack with no request outstanding has no effect.
        bus_ack   = 1'b1;
        bus_rdata = 64'h7777777777777777;
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        check("stray_ack_ready", {63'd0, dcache_ready}, 64'd0);
        check("stray_ack_bus_req", {63'd0, bus_req}, 64'd0);
        run_vec('{1'b0, 64'h8000_0000, 64'h0, 8'h00, 0, 64'h0, 1'b1, 64'h110F0F0F0F0F0F11});

        // Reset during a read miss: transaction abandoned, nothing filled.
        @(posedge clk);
        #1;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 64'h8000_2000;
        @(posedge clk);
        #1;
        mem_req = 1'b0;
        check("midrst_bus_req_pre", {63'd0, bus_req}, 64'd1);
        rst       = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 64'h9999999999999999;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        bus_ack = 1'b0;
        check("midrst_bus_req", {63'd0, bus_req}, 64'd0);
        check("midrst_ready", {63'd0, dcache_ready}, 64'd0);
        run_vec('{1'b0, 64'h8000_2000, 64'h0, 8'h00, 1, 64'h3333333333333333, 1'b0, 64'h3333333333333333});
        run_vec('{1'b0, 64'h8000_0000, 64'h0, 8'h00, 0, 64'h4444444444444444, 1'b0, 64'h4444444444444444});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
